// File: rtl/alu_ops_pkg.sv
// Shared ALU opcode set and datapath constants.
// Used by operand_issue and its register file.
package alu_ops_pkg;

  localparam int REG_W     = 8;
  localparam int NREGS_DEF = 8;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHIFT = 4'd5,
    OP_PASSA = 4'd6,
    OP_PASSB = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [REG_W-1:0] a;
    logic [REG_W-1:0] b;
    logic             sd;
  } alu_drv_t;

endpackage

// File: rtl/operand_issue_regfile.sv
// Architectural register file: two async reads, one sync write.
// Register 0 is hardwired to zero.
module operand_issue_regfile
  import alu_ops_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  ra_a,
  input  logic [RA_W-1:0]  ra_b,
  output logic [REG_W-1:0] rd_a,
  output logic [REG_W-1:0] rd_b,
  input  logic             we,
  input  logic [RA_W-1:0]  wa,
  input  logic [REG_W-1:0] wd
);

  logic [REG_W-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd_a = (ra_a == '0) ? '0 : mem[ra_a];
  assign rd_b = (ra_b == '0) ? '0 : mem[ra_b];

endmodule

// File: rtl/operand_issue.sv
// Operand read / issue stage feeding an external combinational ALU.
// Define OPERAND_ISSUE_FORWARD_EN to bypass alu_out instead of stalling.
module operand_issue
  import alu_ops_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [RA_W-1:0]  instr_rd,
  input  logic [RA_W-1:0]  instr_rs,
  input  logic [RA_W-1:0]  instr_rt,
  input  logic [7:0]       instr_imm,
  input  logic             instr_use_imm,
  input  logic             instr_shift_dir,
  output logic [3:0]       alu_op,
  output logic [7:0]       alu_port_A,
  output logic [7:0]       alu_port_B,
  output logic             alu_shift_dir,
  input  logic [7:0]       alu_out,
  input  logic             alu_eq0,
  input  logic             ex_ready,
  output logic             iss_valid,
  output logic             zero_flag
);

  alu_drv_t         iss;
  logic [RA_W-1:0]  iss_rd;
  logic [REG_W-1:0] rf_a;
  logic [REG_W-1:0] rf_b;
  logic [REG_W-1:0] op_a;
  logic [REG_W-1:0] reg_b;
  logic [REG_W-1:0] op_b;
  logic             retire;
  logic             hit_a;
  logic             hit_b;
  logic             hazard_stall;
  logic             accept;

  assign retire = iss_valid && ex_ready;
  assign hit_a  = iss_rd != '0 && instr_rs == iss_rd;
  assign hit_b  = iss_rd != '0 && !instr_use_imm
               && instr_rt == iss_rd;

`ifdef OPERAND_ISSUE_FORWARD_EN
  assign hazard_stall = 1'b0;
  assign op_a  = (retire && hit_a) ? alu_out : rf_a;
  assign reg_b = (retire && hit_b) ? alu_out : rf_b;
`else
  assign hazard_stall = retire && (hit_a || hit_b);
  assign op_a  = rf_a;
  assign reg_b = rf_b;
`endif

  assign op_b = instr_use_imm ? instr_imm : reg_b;

  assign instr_ready = !reset && (!iss_valid || ex_ready)
                    && !hazard_stall;
  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss       <= '0;
      iss_rd    <= '0;
      iss_valid <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      if (retire) begin
        zero_flag <= alu_eq0;
      end
      if (accept) begin
        iss.op    <= instr_op;
        iss.a     <= op_a;
        iss.b     <= op_b;
        iss.sd    <= instr_shift_dir;
        iss_rd    <= instr_rd;
        iss_valid <= 1'b1;
      end else if (retire) begin
        iss_valid <= 1'b0;
      end
    end
  end

  assign alu_op        = iss.op;
  assign alu_port_A    = iss.a;
  assign alu_port_B    = iss.b;
  assign alu_shift_dir = iss.sd;

  operand_issue_regfile #(
    .NREGS (NREGS),
    .RA_W  (RA_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra_a  (instr_rs),
    .ra_b  (instr_rt),
    .rd_a  (rf_a),
    .rd_b  (rf_b),
    .we    (retire),
    .wa    (iss_rd),
    .wd    (alu_out)
  );

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed vectors against a small ALU model.
// Build with OPERAND_ISSUE_FORWARD_EN to exercise the bypass variant.
module tb_operand_issue;
  import alu_ops_pkg::*;

`ifdef OPERAND_ISSUE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [2:0] instr_rd;
  logic [2:0] instr_rs;
  logic [2:0] instr_rt;
  logic [7:0] instr_imm;
  logic       instr_use_imm;
  logic       instr_shift_dir;
  logic [3:0] alu_op;
  logic [7:0] alu_port_A;
  logic [7:0] alu_port_B;
  logic       alu_shift_dir;
  logic [7:0] alu_out;
  logic       alu_eq0;
  logic       ex_ready;
  logic       iss_valid;
  logic       zero_flag;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_a;
  bit prev_ok;

  always #5 clk = ~clk;

  operand_issue dut (
    .clk             (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_op        (instr_op),
    .instr_rd        (instr_rd),
    .instr_rs        (instr_rs),
    .instr_rt        (instr_rt),
    .instr_imm       (instr_imm),
    .instr_use_imm   (instr_use_imm),
    .instr_shift_dir (instr_shift_dir),
    .alu_op          (alu_op),
    .alu_port_A      (alu_port_A),
    .alu_port_B      (alu_port_B),
    .alu_shift_dir   (alu_shift_dir),
    .alu_out         (alu_out),
    .alu_eq0         (alu_eq0),
    .ex_ready        (ex_ready),
    .iss_valid       (iss_valid),
    .zero_flag       (zero_flag)
  );

  always_comb begin
    alu_out = 8'h00;
    case (alu_op)
      OP_ADD:   alu_out = alu_port_A + alu_port_B;
      OP_SUB:   alu_out = alu_port_A - alu_port_B;
      OP_AND:   alu_out = alu_port_A & alu_port_B;
      OP_OR:    alu_out = alu_port_A | alu_port_B;
      OP_XOR:   alu_out = alu_port_A ^ alu_port_B;
      OP_SHIFT: alu_out = alu_shift_dir ?
                  (alu_port_A >> alu_port_B[2:0]) :
                  (alu_port_A << alu_port_B[2:0]);
      OP_PASSA: alu_out = alu_port_A;
      OP_PASSB: alu_out = alu_port_B;
      default:  alu_out = 8'h00;
    endcase
  end
  assign alu_eq0 = (alu_port_A == 8'h00);

  typedef struct {
    int         gap;
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm;
    logic       ui;
    logic       sd;
    logic [7:0] ea;
    logic [7:0] eb;
    int         stall;
  } vec_t;

  vec_t tbl [16];
  vec_t v;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic issue_chk(input string nm, input vec_t t);
    int waited;
    if (t.gap > 0) begin
      instr_valid = 1'b0;
      repeat (t.gap) @(posedge clk);
      #1;
    end
    instr_op        = t.op;
    instr_rd        = t.rd;
    instr_rs        = t.rs;
    instr_rt        = t.rt;
    instr_imm       = t.imm;
    instr_use_imm   = t.ui;
    instr_shift_dir = t.sd;
    instr_valid     = 1'b1;
    #1;
    waited = 0;
    while (!instr_ready && waited < 8) begin
      @(posedge clk);
      #2;
      waited++;
    end
    chk({nm, "_stall"}, waited, FWD ? 0 : t.stall);
    @(posedge clk);
    #1;
    chk({nm, "_A"}, alu_port_A, t.ea);
    chk({nm, "_B"}, alu_port_B, t.eb);
    chk({nm, "_op"}, alu_op, t.op);
    chk({nm, "_sd"}, alu_shift_dir, t.sd);
    chk({nm, "_iv"}, iss_valid, 1);
    if (prev_ok) chk({nm, "_zf"}, zero_flag, prev_a == 8'h00);
    prev_a  = t.ea;
    prev_ok = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{0, OP_ADD,   3'd1, 3'd0, 3'd0, 8'h03, 1, 0, 8'h00, 8'h03, 0};
    tbl[1]  = '{0, OP_ADD,   3'd2, 3'd1, 3'd0, 8'h04, 1, 0, 8'h03, 8'h04, 1};
    tbl[2]  = '{0, OP_XOR,   3'd3, 3'd2, 3'd1, 8'h00, 0, 0, 8'h07, 8'h03, 1};
    tbl[3]  = '{0, OP_PASSB, 3'd0, 3'd0, 3'd3, 8'hFF, 1, 0, 8'h00, 8'hFF, 0};
    tbl[4]  = '{0, OP_ADD,   3'd5, 3'd0, 3'd0, 8'h01, 1, 0, 8'h00, 8'h01, 0};
    tbl[5]  = '{0, OP_PASSA, 3'd6, 3'd3, 3'd0, 8'h00, 1, 0, 8'h04, 8'h00, 0};
    tbl[6]  = '{0, OP_OR,    3'd7, 3'd6, 3'd5, 8'h00, 0, 0, 8'h04, 8'h01, 1};
    tbl[7]  = '{0, OP_SUB,   3'd1, 3'd7, 3'd5, 8'h00, 0, 0, 8'h05, 8'h01, 1};
    tbl[8]  = '{0, OP_SHIFT, 3'd2, 3'd1, 3'd0, 8'h01, 1, 1, 8'h04, 8'h01, 1};
    tbl[9]  = '{0, OP_PASSA, 3'd0, 3'd2, 3'd0, 8'h00, 1, 0, 8'h02, 8'h00, 1};
    tbl[10] = '{0, OP_PASSB, 3'd1, 3'd0, 3'd0, 8'h80, 1, 0, 8'h00, 8'h80, 0};
    tbl[11] = '{1, OP_PASSA, 3'd7, 3'd1, 3'd0, 8'h00, 1, 0, 8'h80, 8'h00, 0};
    tbl[12] = '{1, OP_PASSB, 3'd1, 3'd0, 3'd0, 8'h00, 1, 0, 8'h00, 8'h00, 0};
    tbl[13] = '{1, OP_SUB,   3'd4, 3'd1, 3'd1, 8'h01, 1, 0, 8'h00, 8'h01, 0};
    tbl[14] = '{1, OP_PASSA, 3'd6, 3'd4, 3'd0, 8'h00, 1, 0, 8'hFF, 8'h00, 0};
    tbl[15] = '{1, OP_ADD,   3'd7, 3'd0, 3'd0, 8'h09, 1, 0, 8'h00, 8'h09, 0};

    reset = 1'b1;
    ex_ready = 1'b1;
    instr_valid = 1'b0;
    instr_op = '0;
    instr_rd = '0;
    instr_rs = '0;
    instr_rt = '0;
    instr_imm = '0;
    instr_use_imm = 1'b0;
    instr_shift_dir = 1'b0;
    prev_a = '0;
    prev_ok = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", instr_ready, 0);
    chk("rst_iv", iss_valid, 0);
    chk("rst_A", alu_port_A, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", instr_ready, 1);
    chk("post_rst_zf", zero_flag, 0);
    chk("post_rst_op", alu_op, 0);

    foreach (tbl[i]) begin
      issue_chk($sformatf("v%0d", i), tbl[i]);
    end
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_zf", zero_flag, 1);
    chk("drain_iv", iss_valid, 0);

    // backpressure: op held for 3 cycles, then a single retire
    ex_ready = 1'b0;
    v = '{0, OP_ADD, 3'd1, 3'd5, 3'd0, 8'h10, 1, 0, 8'h01, 8'h10, 0};
    issue_chk("bp_issue", v);
    instr_op = OP_PASSA;
    instr_rd = 3'd6;
    instr_rs = 3'd0;
    instr_imm = 8'h00;
    instr_use_imm = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_ready", c), instr_ready, 0);
      chk($sformatf("bp%0d_iv", c), iss_valid, 1);
      chk($sformatf("bp%0d_A", c), alu_port_A, 8'h01);
      chk($sformatf("bp%0d_B", c), alu_port_B, 8'h10);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_rel_ready", instr_ready, 1);
    @(posedge clk);
    #1;
    chk("bp_rel_A", alu_port_A, 8'h00);
    chk("bp_rel_zf", zero_flag, 0);
    prev_a = 8'h00;
    v = '{0, OP_PASSA, 3'd3, 3'd1, 3'd0, 8'h00, 1, 0, 8'h11, 8'h00, 0};
    issue_chk("bp_rd_r1", v);
    v = '{0, OP_ADD, 3'd7, 3'd0, 3'd0, 8'h00, 1, 0, 8'h00, 8'h00, 0};
    issue_chk("zf_set", v);
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("zf_set_after", zero_flag, 1);

    // reset while an op sits unretired in the issue register
    ex_ready = 1'b0;
    v = '{0, OP_ADD, 3'd1, 3'd0, 3'd0, 8'h05, 1, 0, 8'h00, 8'h05, 0};
    issue_chk("mid_issue", v);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_iv", iss_valid, 0);
    chk("mid_rst_zf", zero_flag, 0);
    chk("mid_rst_B", alu_port_B, 0);
    chk("mid_rst_op", alu_op, 0);
    chk("mid_rst_ready", instr_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ex_ready = 1'b1;
    prev_ok = 1'b0;
    v = '{0, OP_PASSA, 3'd2, 3'd1, 3'd0, 8'h00, 1, 0, 8'h00, 8'h00, 0};
    issue_chk("mid_r1", v);
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("end_iv", iss_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
